// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed program into instruction memory, then releases the core.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the data.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        busy,
    output logic        error
);
`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR, CSUM} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR} state_t;
`endif
    state_t state, nxt;
    logic [15:0] n, n_cand;
    logic [ADDR_W-1:0] idx;
    logic [1:0] bcnt;
    logic [16:0] idx_inc;
    logic xfer, last, bad_n, start_ok, nxt_busy;
    always_comb begin
        n_cand   = {n[15:8], byte_data};
        bad_n    = (n_cand == 16'd0) || (n_cand > 16'(MAX_WORDS));
        idx_inc  = 17'(idx) + 17'd1;
        last     = idx_inc == {1'b0, n};
        start_ok = start && (state == IDLE || state == DONE || state == ERR);
`ifdef IMEM_LOADER_CSUM_EN
        byte_ready = state inside {HDR_HI, HDR_LO, DATA, CSUM};
        nxt_busy   = nxt inside {HDR_HI, HDR_LO, DATA, WRITE, CSUM};
`else
        byte_ready = state inside {HDR_HI, HDR_LO, DATA};
        nxt_busy   = nxt inside {HDR_HI, HDR_LO, DATA, WRITE};
`endif
        xfer = byte_valid && byte_ready;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? HDR_HI : state;
            HDR_HI:          nxt = xfer ? HDR_LO : state;
            HDR_LO:          nxt = xfer ? (bad_n ? ERR : DATA) : state;
            DATA:            nxt = (xfer && bcnt == 2'd3) ? WRITE : state;
`ifdef IMEM_LOADER_CSUM_EN
            WRITE:           nxt = last ? CSUM : DATA;
            CSUM:            nxt = xfer ? ((csum == byte_data) ? DONE : ERR) : state;
`else
            WRITE:           nxt = last ? DONE : DATA;
`endif
            default:         nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            idx       <= '0;
            bcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            state   <= nxt;
            mem_we  <= nxt == WRITE;
            cpu_run <= nxt == DONE;
            error   <= nxt == ERR;
            busy    <= nxt_busy;
            if (start_ok) begin
                idx  <= '0;
                bcnt <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum <= '0;
`endif
            end
            if (xfer && state == HDR_HI) n[15:8] <= byte_data;
            if (xfer && state == HDR_LO) n[7:0] <= byte_data;
            if (xfer && state == DATA) begin
                mem_wdata <= {mem_wdata[23:0], byte_data};
                mem_addr  <= {{(30-ADDR_W){1'b0}}, idx, 2'b00};
                bcnt      <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                csum      <= csum ^ byte_data;
`endif
            end
            if (state == WRITE) idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for the instruction-memory boot loader.
// Expected writes are queued as bytes are driven and popped when mem_we is seen.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, mem_we, cpu_run, busy, error;
    logic [31:0] mem_addr, mem_wdata;
    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  csum_acc = 8'h00;
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
        .busy(busy), .error(error)
    );

    always @(negedge clk) begin
        logic [63:0] e;
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             mem_addr, mem_wdata, e[63:32], e[31:0]);
                end
            end
        end
        if (mem_we && prev_we) begin
            checks++;
            errors++;
            $display("FAIL we_width mem_we held 2 cycles want 1");
        end
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready) break;
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout byte=%h ready=%b want 1", b, byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n, input bit gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gap);
        exp_q.push_back({addr, w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], gap);
            csum_acc ^= w[31-8*k -: 8];
        end
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL we_latency got %b want 1 after 4th byte", mem_we);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        csum_acc = 8'h00;
    endtask

    task automatic finish_frame(input bit good);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(good ? csum_acc : csum_acc ^ 8'h01, 1'b0);
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL settle_timeout busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({mem_we, cpu_run, busy, error, byte_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {mem_we, cpu_run, busy, error, byte_ready});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0", {mem_addr, mem_wdata});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        byte_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({byte_ready, busy, cpu_run} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 000", {byte_ready, busy, cpu_run});
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_basic(input bit gap);
        pulse_start();
        checks++;
        if ({busy, byte_ready, cpu_run} !== 3'b110) begin
            errors++;
            $display("FAIL start_state got %b want 110", {busy, byte_ready, cpu_run});
        end
        send_header(16'd2, gap);
        send_word(32'h20080005, 32'h0, gap);
        send_word(32'h0000000C, 32'h4, gap);
        finish_frame(1'b1);
        checks++;
        if ({cpu_run, error} !== 2'b10) begin
            errors++;
            $display("FAIL done_flags gap=%0d got %b want 10", gap, {cpu_run, error});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_bad_len();
        pulse_start();
        checks++;
        if (cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL run_drop got %b want 0", cpu_run);
        end
        send_header(16'h0000, 1'b0);
        checks++;
        if ({error, cpu_run, byte_ready, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL zero_len got %b want 1000", {error, cpu_run, byte_ready, busy});
        end
        pulse_start();
        checks++;
        if ({error, busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_clear got %b want 01", {error, busy});
        end
        send_header(16'h0101, 1'b0);
        checks++;
        if ({error, cpu_run, byte_ready} !== 3'b100) begin
            errors++;
            $display("FAIL over_len got %b want 100", {error, cpu_run, byte_ready});
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_header(16'd2, 1'b0);
        send_word(32'hA5A55A5A, 32'h0, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, cpu_run, busy, error, byte_ready, mem_addr, mem_wdata} !== 69'h0) begin
            errors++;
            $display("FAIL async_reset got we=%b busy=%b data=%h want all 0", mem_we, busy, mem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        byte_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, byte_ready, cpu_run, mem_we} !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 0000", {busy, byte_ready, cpu_run, mem_we});
        end
        byte_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL word0_write got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        pulse_start();
        send_header(16'd2, 1'b0);
        pulse_start();
        checks++;
        if ({busy, byte_ready} !== 2'b11) begin
            errors++;
            $display("FAIL start_ignored got %b want 11", {busy, byte_ready});
        end
        send_word(32'h01234567, 32'h0, 1'b0);
        send_word(32'h89ABCDEF, 32'h4, 1'b0);
        finish_frame(1'b1);
        checks++;
        if (cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL run_after_busy_start got %b want 1", cpu_run);
        end
        pulse_start();
        checks++;
        if ({cpu_run, busy} !== 2'b01) begin
            errors++;
            $display("FAIL restart_from_done got %b want 01", {cpu_run, busy});
        end
        send_header(16'd1, 1'b1);
        send_word(32'hDEADBEEF, 32'h0, 1'b0);
        finish_frame(1'b1);
        checks++;
        if ({cpu_run, error, exp_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL reload got run=%b err=%b pending=%0d want 1 0 0", cpu_run, error, exp_q.size());
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        pulse_start();
        send_header(16'd1, 1'b0);
        send_word(32'h12345678, 32'h0, 1'b0);
        send_byte(8'h08, 1'b0);
        checks++;
        if ({cpu_run, error} !== 2'b10) begin
            errors++;
            $display("FAIL csum_good got %b want 10", {cpu_run, error});
        end
        pulse_start();
        send_header(16'd1, 1'b0);
        send_word(32'h12345678, 32'h0, 1'b0);
        send_byte(8'h09, 1'b0);
        checks++;
        if ({cpu_run, error} !== 2'b01) begin
            errors++;
            $display("FAIL csum_bad got %b want 01", {cpu_run, error});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_bad_len();
        test_reset_mid();
        test_start_busy();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
